// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler sharing one serial binary-to-BCD converter
module bcd_conv_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_bcd,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic [15:0]          conv_hex,
    output logic                 conv_start,
    input  logic                 conv_busy,
    input  logic [15:0]          conv_bcd,
    output logic                 sched_busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [5:0]      tcnt;
    logic [15:0]     operand;

    logic [15:0]     req_word [NREQ];
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick;
    logic            pick_found;

    for (genvar g = 0; g < NREQ; g++) begin : g_word
        assign req_word[g] = req_data[16*g +: 16];
    end

    // Scan from the farthest candidate down so the nearest set bit above ptr wins.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    function automatic logic [17:0] pack_rsp(input logic err, input logic [15:0] op,
                                             input logic [15:0] bcd);
        if (err)
            return {1'b1, 1'b0, 16'hFFFF};
        else if (op > 16'd9999)
            return {1'b0, 1'b1, 16'h9999};
        else
            return {1'b0, 1'b0, bcd};
    endfunction

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            winner     <= '0;
            tcnt       <= '0;
            operand    <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_bcd    <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            conv_hex   <= '0;
            conv_start <= 1'b0;
            sched_busy <= 1'b0;
        end else begin
            req_ready  <= '0;
            rsp_valid  <= '0;
            conv_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        winner     <= pick;
                        operand    <= req_word[pick];
                        conv_hex   <= req_word[pick];
                        req_ready  <= NREQ'(1) << pick;
                        conv_start <= 1'b1;
                        sched_busy <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ptr   <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    tcnt  <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (conv_busy) begin
                        tcnt  <= '0;
                        state <= WAIT_DONE;
                    end else if (tcnt == 6'(TIMEOUT)) begin
                        rsp_valid                   <= NREQ'(1) << winner;
                        {rsp_err, rsp_ovf, rsp_bcd} <= pack_rsp(1'b1, operand, conv_bcd);
                        state                       <= RESP;
                    end else begin
                        tcnt <= tcnt + 6'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!conv_busy) begin
                        rsp_valid                   <= NREQ'(1) << winner;
                        {rsp_err, rsp_ovf, rsp_bcd} <= pack_rsp(1'b0, operand, conv_bcd);
                        state                       <= RESP;
                    end else if (tcnt == 6'(TIMEOUT)) begin
                        rsp_valid                   <= NREQ'(1) << winner;
                        {rsp_err, rsp_ovf, rsp_bcd} <= pack_rsp(1'b1, operand, conv_bcd);
                        state                       <= RESP;
                    end else begin
                        tcnt <= tcnt + 6'd1;
                    end
                end
                RESP: begin
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - randomized self-checking bench for bcd_conv_sched
module tb_bcd_conv_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 63;

    logic                 sys_clk   = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_data  = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_bcd;
    logic                 rsp_ovf;
    logic                 rsp_err;
    logic [15:0]          conv_hex;
    logic                 conv_start;
    logic                 conv_busy = 1'b0;
    logic [15:0]          conv_bcd  = '0;
    logic                 sched_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: pending requests, their operands, round-robin pointer
    logic [NREQ-1:0] pend = '0;
    logic [15:0]     data_q [NREQ];
    int              ptr_m = 0;

    // converter model: 0 normal, 1 never busy, 2 busy stuck high
    int          conv_mode = 0;
    int          busy_len  = 17;
    int          cm_cnt    = 0;
    logic        cm_pend   = 1'b0;
    logic [15:0] cm_val    = '0;

    bcd_conv_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_bcd    (rsp_bcd),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err),
        .conv_hex   (conv_hex),
        .conv_start (conv_start),
        .conv_busy  (conv_busy),
        .conv_bcd   (conv_bcd),
        .sched_busy (sched_busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_rsp(input logic [15:0] op, input int mode);
        if (mode != 0)          return 16'hFFFF;
        else if (op > 16'd9999) return 16'h9999;
        else                    return to_bcd(int'(op));
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // busy rises one cycle after start and stays high for busy_len cycles
    always @(posedge sys_clk) begin
        if (conv_mode == 1) begin
            conv_busy <= 1'b0; cm_pend <= 1'b0; cm_cnt <= 0;
        end else if (conv_mode == 2) begin
            conv_busy <= 1'b1; cm_pend <= 1'b0; cm_cnt <= 0;
        end else if (conv_start) begin
            cm_pend <= 1'b1;
            cm_cnt  <= busy_len;
            cm_val  <= to_bcd(int'(conv_hex) % 10000);
        end else if (cm_pend) begin
            cm_pend   <= 1'b0;
            conv_busy <= 1'b1;
        end else if (conv_busy) begin
            if (cm_cnt <= 1) begin
                conv_busy <= 1'b0;
                conv_bcd  <= cm_val;
            end
            cm_cnt <= cm_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pend  = '0;
        ptr_m = 0;
    endtask

    // One full transaction from the current pending set; returns the granted index.
    task automatic run_one(input int mode, input int blen, output int w);
        int          n;
        int          lat;
        logic [15:0] op;
        @(negedge sys_clk);
        conv_mode = mode;
        busy_len  = blen;
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = data_q[i];
        w  = rr_pick(pend, ptr_m);
        op = data_q[w];
        @(posedge sys_clk); #1;
        check("accept", 32'(req_ready), 32'(1 << w));
        check("start", 32'(conv_start), 32'd1);
        check("conv_hex", 32'(conv_hex), 32'(op));
        ptr_m = (w + 1) % NREQ;
        @(negedge sys_clk);
        pend[w]      = 1'b0;
        req_valid[w] = 1'b0;
        req_data[16*w +: 16] = (op == 16'd1234) ? 16'd5678 : 16'($urandom);
        @(posedge sys_clk); #1;
        check("hex_hold", 32'(conv_hex), 32'(op));
        n = 1;
        while (rsp_valid == '0 && n < 300) begin
            @(posedge sys_clk); #1;
            n++;
        end
        lat = (mode == 0) ? blen + 3 : (mode == 1) ? TIMEOUT + 2 : TIMEOUT + 3;
        check("latency", 32'(n), 32'(lat));
        check("rsp_valid", 32'(rsp_valid), 32'(1 << w));
        check("rsp_bcd", 32'(rsp_bcd), 32'(exp_rsp(op, mode)));
        check("rsp_ovf", 32'(rsp_ovf), 32'(mode == 0 && op > 16'd9999));
        check("rsp_err", 32'(rsp_err), 32'(mode != 0));
        check("busy_resp", 32'(sched_busy), 32'd1);
        @(posedge sys_clk); #1;
        check("busy_idle", 32'(sched_busy), 32'd0);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        for (int i = 0; i < NREQ; i++) data_q[i] = '0;

        do_reset();
        #1;
        check("reset_outs", {req_ready, rsp_valid, rsp_bcd, rsp_ovf, rsp_err, conv_start, sched_busy}, 32'd0);
        check("reset_hex", 32'(conv_hex), 32'd0);

        // all requesters continuously active: strict order 0,1,2,3,0
        pend = '1;
        for (int i = 0; i < NREQ; i++) data_q[i] = 16'($urandom_range(0, 9999));
        for (int t = 0; t < 5; t++) begin
            run_one(0, int'($urandom_range(1, 20)), w);
            pend[w]   = 1'b1;
            data_q[w] = 16'($urandom_range(0, 9999));
        end
        pend = '0;

        // single request, latency and data-latching
        pend = 4'b0100; data_q[2] = 16'd1234;
        run_one(0, 17, w);

        pend = 4'b0001; data_q[0] = 16'd10000;
        run_one(0, 17, w);
        pend = 4'b0001; data_q[0] = 16'd9999;
        run_one(0, 17, w);

        // stuck converter, each followed by a normal transaction
        pend = 4'b0010; data_q[1] = 16'd42;
        run_one(1, 17, w);
        pend = 4'b0010; data_q[1] = 16'd77;
        run_one(0, 10, w);
        pend = 4'b1000; data_q[3] = 16'd500;
        run_one(2, 17, w);
        pend = 4'b1000; data_q[3] = 16'd8001;
        run_one(0, 10, w);

        // reset in the middle of WAIT_DONE aborts without a response
        @(negedge sys_clk);
        conv_mode = 0; busy_len = 17;
        req_valid = 4'b0010; req_data[16 +: 16] = 16'd4321;
        @(posedge sys_clk); #1;
        check("abort_accept", 32'(req_ready), 32'h2);
        @(negedge sys_clk);
        req_valid = '0;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check("abort_outs", {req_ready, rsp_valid, rsp_bcd, rsp_ovf, rsp_err, conv_start, sched_busy}, 32'd0);
        check("abort_hex", 32'(conv_hex), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pend = '0; ptr_m = 0;
        n = 0;
        repeat (30) begin
            @(posedge sys_clk); #1;
            if (rsp_valid != '0) n++;
        end
        check("abort_no_rsp", 32'(n), 32'd0);
        pend = 4'b1011;
        for (int i = 0; i < NREQ; i++) data_q[i] = 16'(100 * (i + 1));
        run_one(0, 6, w);
        pend = 4'b1000; data_q[3] = 16'd2468;
        run_one(0, 6, w);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int mode;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    data_q[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10050));
                end
            end
            if (pend == '0) begin
                pend[0]   = 1'b1;
                data_q[0] = 16'($urandom_range(0, 9999));
            end
            mode = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_one(mode, int'($urandom_range(1, 20)), w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
Round-robin scheduler that shares one serial binary-to-BCD converter (4-digit, busy-flagged, about 17-cycle conversion) among NREQ requesters, e.g. several status counters that feed front-panel or DDL slow-control displays.
- Accepts one request at a time and latches its operand into the converter.
- Launches the conversion and waits for completion (busy falling edge).
- Returns the BCD result to the granted requester as a one-cycle response.
- Guards against overflow and a stuck converter.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 63, max cycles allowed in each converter wait state before error (6-bit counter, 1..63)

Ports:
sys_clk  in  1  system clock, all logic rising-edge
sys_rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request, level, held until accepted
req_data  in  16*NREQ  operands; requester i on bits [16i+15:16i]
req_ready  out  NREQ  one-hot one-cycle accept pulse
rsp_valid  out  NREQ  one-hot one-cycle response pulse
rsp_bcd  out  16  BCD result, valid when any rsp_valid bit set
rsp_ovf  out  1  operand > 9999; rsp_bcd forced to 16'h9999
rsp_err  out  1  converter timeout; rsp_bcd = 16'hFFFF
conv_hex  out  16  operand to converter, held stable from LAUNCH through WAIT_DONE
conv_start  out  1  one-cycle start pulse to converter
conv_busy  in  1  converter busy flag
conv_bcd  in  16  converter result, valid once conv_busy has fallen
sched_busy  out  1  high in any state except IDLE

Behaviour:
- Reset: sys_rst_n=0 sampled at a rising edge puts the block in IDLE.
  - All outputs 0.
  - Round-robin pointer = 0; timeout counter = 0.
  - A reset asserted mid-operation aborts that operation. No response is issued for the aborted request.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If req_valid != 0, select the winner: the first set bit searching upward from the pointer, with wrap-around.
  - Register the winner index and its operand, then go to LAUNCH.
  - If req_valid == 0, stay in IDLE.
- LAUNCH (1 cycle):
  - req_ready[winner]=1 and conv_start=1; conv_hex = latched operand.
  - Pointer <= (winner+1) mod NREQ.
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - conv_busy=1 → go to WAIT_DONE and clear the counter.
  - Counter reaches TIMEOUT → go to RESP with error set.
  - Otherwise increment the counter.
- WAIT_DONE:
  - conv_busy=0 → capture conv_bcd and go to RESP.
  - Counter reaches TIMEOUT → go to RESP with error set.
- RESP (1 cycle):
  - rsp_valid[winner]=1.
  - Priority: err → rsp_bcd=16'hFFFF, rsp_err=1, rsp_ovf=0. Otherwise, operand > 9999 (16-bit unsigned compare) → rsp_bcd=16'h9999, rsp_ovf=1. Otherwise rsp_bcd = captured value.
  - Then go to IDLE.
- rsp_bcd, rsp_ovf and rsp_err hold their last values after RESP. They are meaningful only while rsp_valid is set.
- Latency, request seen in IDLE to accept: req_ready pulses 1 cycle later (in LAUNCH).
- Latency, normal path to response: LAUNCH + WAIT_BUSY (≥1 cycle) + WAIT_DONE (≥1 cycle) + RESP, i.e. conversion time + 3 cycles minimum.
- Minimum spacing between two accepts is 5 cycles.
- The operand is sampled in IDLE. Requester changes to req_data after that cycle have no effect.
- If req_valid[winner] drops between selection and LAUNCH, the request is still executed with the latched operand.
- Simultaneous requests: exactly one grant, in strict round-robin order. No requester waits more than NREQ-1 other transactions.
- conv_busy already high in LAUNCH is ignored. The WAIT_BUSY check starts the cycle after conv_start.

Test Plan:
- Single request, requester 2, data 16'd1234, converter model returns 16'h1234 after 17 busy cycles → req_ready=4'b0100 one cycle after request; rsp_valid=4'b0100 at 17+3 cycles after LAUNCH; rsp_bcd=16'h1234; ovf=0; err=0.
- All four requesting continuously, pointer at 0 after reset → accept order 0,1,2,3,0; each rsp_valid matches the preceding req_ready index.
- Overflow: data 16'd10000 → rsp_bcd=16'h9999, rsp_ovf=1. Data 16'd9999 → 16'h9999 with rsp_ovf=0.
- Converter never raises busy → rsp_err=1, rsp_bcd=16'hFFFF after 63 cycles in WAIT_BUSY; the next request is accepted normally. Repeat with busy stuck high → error from WAIT_DONE.
- Reset pulse (sys_rst_n=0 for one edge) during WAIT_DONE → no rsp_valid; all outputs 0; pointer 0; the next request from requester 3 is granted normally.
- req_data changed the cycle after selection (1234 → 5678) → conv_hex and result reflect 1234.
